// File: rtl/div_reconstructor.sv
// Pipelined dividend rebuilder: dividend = quotient * divisor + remainder.
// Shift-add, one divisor bit per stage, one operation per clock, fixed latency of DIVISOR_W.
module div_reconstructor #(
    parameter int DIVISOR_W  = 16,
    parameter int DIVIDEND_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DIVIDEND_W-1:0] quotient,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic [DIVIDEND_W-1:0] remainder,
    output logic                  valid_out,
    output logic [DIVIDEND_W-1:0] dividend,
    output logic                  overflow,
    output logic                  rem_err
);

    localparam int ACC_W = DIVIDEND_W + DIVISOR_W;

    // Index 0 is the accept register; index k holds partial sums of divisor bits below k.
    logic [ACC_W-1:0]      r_acc  [DIVISOR_W];
    logic [DIVIDEND_W-1:0] r_q    [DIVISOR_W];
    logic [DIVISOR_W-1:0]  r_d    [DIVISOR_W];
    logic                  r_rerr [DIVISOR_W];
    logic                  r_vld  [DIVISOR_W];

    logic [ACC_W-1:0]      w_sum  [DIVISOR_W];

    always_comb begin
        for (int k = 0; k < DIVISOR_W; k++) begin
            w_sum[k] = r_acc[k];
            if (r_d[k][k]) begin
                w_sum[k] = r_acc[k] + (ACC_W'(r_q[k]) << k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DIVISOR_W; k++) begin
                r_acc[k]  <= '0;
                r_q[k]    <= '0;
                r_d[k]    <= '0;
                r_rerr[k] <= 1'b0;
                r_vld[k]  <= 1'b0;
            end
            valid_out <= 1'b0;
            dividend  <= '0;
            overflow  <= 1'b0;
            rem_err   <= 1'b0;
        end else begin
            r_vld[0] <= valid_in;
            if (valid_in) begin
                r_acc[0]  <= ACC_W'(remainder);
                r_q[0]    <= quotient;
                r_d[0]    <= divisor;
                r_rerr[0] <= (remainder >= DIVIDEND_W'(divisor));
            end
            for (int k = 1; k < DIVISOR_W; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_acc[k]  <= w_sum[k-1];
                    r_q[k]    <= r_q[k-1];
                    r_d[k]    <= r_d[k-1];
                    r_rerr[k] <= r_rerr[k-1];
                end
            end
            // The last divisor bit is folded into the output register to keep latency at DIVISOR_W.
            valid_out <= r_vld[DIVISOR_W-1];
            if (r_vld[DIVISOR_W-1]) begin
                dividend <= w_sum[DIVISOR_W-1][DIVIDEND_W-1:0];
                overflow <= |w_sum[DIVISOR_W-1][ACC_W-1:DIVIDEND_W];
                rem_err  <= r_rerr[DIVISOR_W-1];
            end
        end
    end

endmodule

// File: tb/tb_div_reconstructor.sv
// Scoreboard bench for div_reconstructor: directed and random operations, latency,
// hold behaviour between results, and async reset clearing in-flight work.
module tb_div_reconstructor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] quotient = '0;
    logic [15:0] divisor = '0;
    logic [31:0] remainder = '0;
    logic        valid_out;
    logic [31:0] dividend;
    logic        overflow;
    logic        rem_err;

    div_reconstructor #(.DIVISOR_W(16), .DIVIDEND_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .valid_out (valid_out),
        .dividend  (dividend),
        .overflow  (overflow),
        .rem_err   (rem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] div;
        logic        ov;
        logic        re;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] last_div = '0;
    logic        last_ov = 1'b0;
    logic        last_re = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Result arrives 17 sampled cycles after the negedge on which it is driven.
    task automatic issue_exp(input logic [31:0] q, input logic [15:0] d, input logic [31:0] r,
                             input logic [31:0] ediv, input logic eov, input logic ere);
        exp_t e;
        @(negedge clk);
        valid_in  = 1'b1;
        quotient  = q;
        divisor   = d;
        remainder = r;
        e.div = ediv;
        e.ov  = eov;
        e.re  = ere;
        e.cyc = cyc + 17;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] q, input logic [15:0] d, input logic [31:0] r);
        logic [47:0] t;
        t = {16'd0, q} * {32'd0, d} + {16'd0, r};
        issue_exp(q, d, r, t[31:0], |t[47:32], r >= {16'd0, d});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in  = 1'b0;
            quotient  = $urandom;
            divisor   = 16'($urandom);
            remainder = $urandom;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            logic exp_v;
            exp_t e;
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missing_result", 32'(sb[0].cyc), 32'(cyc));
                void'(sb.pop_front());
            end
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
            if (exp_v) begin
                e = sb.pop_front();
                chk("dividend", dividend, e.div);
                chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                chk("rem_err", {31'd0, rem_err}, {31'd0, e.re});
                last_div = e.div;
                last_ov  = e.ov;
                last_re  = e.re;
            end else begin
                chk("hold_dividend", dividend, last_div);
                chk("hold_flags", {30'd0, overflow, rem_err}, {30'd0, last_ov, last_re});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: observed no finish, expected finish before 300000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with live-looking input traffic.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_in  = 1'b1;
            quotient  = $urandom;
            divisor   = 16'($urandom);
            remainder = $urandom;
            chk("rst_outputs", {valid_out, overflow, rem_err, 29'd0} | dividend, 32'd0);
        end
        @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b1;

        issue_exp(32'd21191, 16'd25347, 32'd4971, 32'd537133248, 1'b0, 1'b0);
        idle(20);

        // Back-to-back.
        issue_exp(32'd21191, 16'd25347, 32'd4971, 32'd537133248, 1'b0, 1'b0);
        issue_exp(32'd27130, 16'd25443, 32'd6933, 32'd690275523, 1'b0, 1'b0);
        issue_exp(32'd179044416, 16'd3, 32'd0, 32'd537133248, 1'b0, 1'b0);
        idle(1);

        // Bubbles: hold of 690275523 across the gap is checked by the monitor.
        issue_exp(32'd27130, 16'd25443, 32'd6933, 32'd690275523, 1'b0, 1'b0);
        idle(3);
        issue_exp(32'd21191, 16'd25347, 32'd4971, 32'd537133248, 1'b0, 1'b0);
        idle(20);

        // Overflow and width edges: 0xFFFFFFFF * 0x10000 = 0xFFFF_FFFF_0000.
        issue_exp(32'hFFFF_FFFF, 16'd2, 32'd0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        issue_exp(32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 1'b1, 1'b1);
        issue_exp(32'hFFFF_FFFF, 16'h8000, 32'd0, 32'hFFFF_8000, 1'b1, 1'b0);
        // Remainder check, divisor zero, quotient zero.
        issue_exp(32'd5, 16'd0, 32'd7, 32'd7, 1'b0, 1'b1);
        issue_exp(32'd4, 16'd10, 32'd10, 32'd50, 1'b0, 1'b1);
        issue_exp(32'd4, 16'd10, 32'd9, 32'd49, 1'b0, 1'b0);
        issue_exp(32'd0, 16'd1234, 32'd99, 32'd99, 1'b0, 1'b0);
        idle(20);

        // Random traffic with random gaps.
        for (int i = 0; i < 40; i++) begin
            issue($urandom, 16'($urandom), (i % 4 == 0) ? 32'($urandom_range(0, 1000)) : $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(20);

        // Async reset mid-flight: 4 ops, pulse reset between edges 8 cycles after the first.
        issue(32'd1000, 16'd77, 32'd5);
        issue(32'd123456, 16'd999, 32'd12);
        issue(32'hDEAD_BEEF, 16'hBEEF, 32'd3);
        issue(32'd42, 16'd42, 32'd41);
        idle(1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        last_div = '0;
        last_ov  = 1'b0;
        last_re  = 1'b0;
        #1;
        chk("async_clear", {valid_out, overflow, rem_err, 29'd0} | dividend, 32'd0);
        #2;
        reset = 1'b1;
        idle(25);

        issue_exp(32'd21191, 16'd25347, 32'd4971, 32'd537133248, 1'b0, 1'b0);
        idle(20);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
